cmp_operand_sequencer: RTL and testbench
========================================

Name: cmp_operand_sequencer

Overview:
- Sequencer in the ULA that feeds the 8-bit tri-state comparison unit and consumes its 6-bit flag output.
- Loads operand A, then operand B, from a shared 8-bit input stream with a valid/ready handshake, then drives the operands and the comparator enable.
- After a programmable settle time it captures the comparator flags, checks them for consistency, and holds them on a valid/ready output until they are consumed.
- Releases the comparator enable outside the evaluation window so the comparator's flag bus floats (Z) for other ULA units.

Parameters:
- WIDTH, 8, operand width; must match the comparator.
- SETTLE, 1, cycles cmp_en is held before flags are sampled; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- in_data  in  WIDTH  operand beat; first beat is A, second beat is B.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer can accept a beat.
- op_a  out  WIDTH  registered operand A, to the comparator a input.
- op_b  out  WIDTH  registered operand B, to the comparator b input.
- cmp_en  out  1  comparator output enable; registered.
- cmp_flags  in  6  comparator flag bus (Z when cmp_en=0). Bit map: [0] a>b, [1] a<b, [2] a>=b, [3] a<=b, [4] a==b, [5] a!=b.
- out_flags  out  6  captured flags.
- out_err  out  1  captured flags failed the consistency check.
- out_valid  out  1  out_flags/out_err valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; op_a=0, op_b=0, cmp_en=0, out_flags=0, out_err=0, out_valid=0, settle counter=0. in_ready=1 in the cycle after reset releases. Reset mid-operation abandons any partial operand or held result; the comparator bus floats immediately.
- in_ready is 1 in IDLE and LOAD_B only; it is a Moore output of state.
- IDLE: on in_valid&in_ready, op_a<=in_data and go to LOAD_B.
- LOAD_B: on a handshake, op_b<=in_data, cmp_en<=1, counter<=SETTLE-1, go to EVAL. With no handshake, stay; op_a is held indefinitely.
- EVAL: cmp_en=1. When counter==0:
  - out_flags<=cmp_flags and out_err<=check failure.
  - out_valid<=1, cmp_en<=0, go to HOLD.
  - Otherwise decrement the counter.
- Consistency check fails if any of these hold: f[0]!=~f[3]; f[1]!=~f[2]; f[4]!=(f[2]&f[3]); f[5]!=(f[2]^f[3]). out_flags is captured verbatim even when out_err=1.
- HOLD: out_valid=1, and out_flags/out_err are stable. On out_valid&out_ready, out_valid<=0 and go to IDLE. in_ready stays 0 until IDLE, so there is no overlap between a held result and a new operand.
- Latency with SETTLE=S: A accepted at edge n, B at edge n+1, flags sampled at edge n+1+S, so out_valid is high from cycle n+2+S.
- op_a/op_b are held after EVAL until they are overwritten by the next load.
- Comparison semantics are unsigned; this block does no arithmetic on the operands.
- Counter width is 4 bits.
- No output is combinational from cmp_flags.

Decomposition:
- Shared package/header holds:
  - state encoding IDLE=2'd0, LOAD_B=2'd1, EVAL=2'd2, HOLD=2'd3;
  - flag bit-index constants FLAG_GT..FLAG_NE = 0..5;
  - the FLAGS_W=6 constant.
- One natural sub-module: cmp_flag_checker (purely combinational, 6-bit in, err out), reusable by other ULA flag consumers.
- The FSM and registers stay in the top module.

Test Plan:
- Reset release, then A=0x05, B=0x03, SETTLE=1, out_ready=1 -> out_flags=6'h25, out_err=0. out_valid rises 3 cycles after A accepted. cmp_en is high exactly 1 cycle.
- A=0x7F, B=0x7F -> out_flags=6'h1C, out_err=0. A=0x00, B=0xFF -> 6'h2A. A=0x80, B=0x7F -> 6'h25 (unsigned).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_flags stable, in_ready=0, an in_valid pulse is ignored. out_ready=1 -> returns to IDLE next cycle.
- Bench comparator model forces flags=6'h3F -> out_err=1, out_flags=6'h3F.
- SETTLE=4 -> cmp_en high exactly 4 cycles, flags sampled on the 4th. in_valid gaps between A and B hold op_a.
- rst_n=0 asserted in EVAL and in HOLD -> next edge: cmp_en=0, out_valid=0, state IDLE, op_a=op_b=0.

Source files
------------

// File: rtl/cmp_operand_sequencer_pkg.sv
// rtl/cmp_operand_sequencer_pkg.sv - shared constants and state encoding for the comparator operand sequencer
package cmp_operand_sequencer_pkg;

    localparam int FLAGS_W = 6;
    localparam int CNT_W   = 4;

    // Comparator flag bus bit positions
    localparam int FLAG_GT = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_GE = 2;
    localparam int FLAG_LE = 3;
    localparam int FLAG_EQ = 4;
    localparam int FLAG_NE = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        EVAL   = 2'd2,
        HOLD   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cmp_operand_sequencer_if.sv
// rtl/cmp_operand_sequencer_if.sv - operand stream, comparator and result bundle of the operand sequencer
interface cmp_operand_sequencer_if #(
    parameter int WIDTH = 8
);
    import cmp_operand_sequencer_pkg::*;

    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               cmp_en;
    logic [FLAGS_W-1:0] cmp_flags;
    logic [FLAGS_W-1:0] out_flags;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  in_data, in_valid, cmp_flags, out_ready,
        output in_ready, op_a, op_b, cmp_en, out_flags, out_err, out_valid
    );

    modport slave (
        output in_data, in_valid, cmp_flags, out_ready,
        input  in_ready, op_a, op_b, cmp_en, out_flags, out_err, out_valid
    );

endinterface

// File: rtl/cmp_operand_sequencer_checker.sv
// rtl/cmp_operand_sequencer_checker.sv - combinational consistency check of a 6-bit comparator flag word
module cmp_flag_checker
    import cmp_operand_sequencer_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags,
    output logic               err
);

    logic gt_bad;
    logic lt_bad;
    logic eq_bad;
    logic ne_bad;

    // gt/lt must be the exact complements of le/ge; eq/ne derive from ge and le
    assign gt_bad = flags[FLAG_GT] != ~flags[FLAG_LE];
    assign lt_bad = flags[FLAG_LT] != ~flags[FLAG_GE];
    assign eq_bad = flags[FLAG_EQ] != (flags[FLAG_GE] & flags[FLAG_LE]);
    assign ne_bad = flags[FLAG_NE] != (flags[FLAG_GE] ^ flags[FLAG_LE]);

    assign err = gt_bad | lt_bad | eq_bad | ne_bad;

endmodule

// File: rtl/cmp_operand_sequencer.sv
// rtl/cmp_operand_sequencer.sv - loads A then B, enables the comparator, captures and checks its flags
module cmp_operand_sequencer
    import cmp_operand_sequencer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmp_operand_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

    seq_state_e         state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   op_a_q,      op_a_d;
    logic [WIDTH-1:0]   op_b_q,      op_b_d;
    logic               cmp_en_q,    cmp_en_d;
    logic               in_ready_q,  in_ready_d;
    logic [FLAGS_W-1:0] out_flags_q, out_flags_d;
    logic               out_err_q,   out_err_d;
    logic               out_valid_q, out_valid_d;
    logic               flag_err;
    logic               in_hs;

    cmp_flag_checker u_checker (
        .flags (bus.cmp_flags),
        .err   (flag_err)
    );

    assign in_hs = bus.in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cmp_en_d    = cmp_en_q;
        out_flags_d = out_flags_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    op_a_d  = bus.in_data;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    op_b_d   = bus.in_data;
                    cmp_en_d = 1'b1;
                    cnt_d    = SETTLE_M1;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                // Flags are captured verbatim; the checker only annotates them
                if (cnt_q == '0) begin
                    out_flags_d = bus.cmp_flags;
                    out_err_d   = flag_err;
                    out_valid_d = 1'b1;
                    cmp_en_d    = 1'b0;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered Moore decode of the next state keeps in_ready glitch-free
        in_ready_d = (state_d == IDLE) || (state_d == LOAD_B);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cmp_en_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_flags_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cmp_en_q    <= cmp_en_d;
            in_ready_q  <= in_ready_d;
            out_flags_q <= out_flags_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.cmp_en    = cmp_en_q;
    assign bus.out_flags = out_flags_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// tb/tb_cmp_operand_sequencer.sv - directed bench for the comparator operand sequencer (SETTLE=1 and SETTLE=4)
module tb_cmp_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic [7:0] tb_in_data;
    logic       tb_in_valid;
    logic       tb_out_ready;
    logic       tb_force;
    int         n_checks;
    int         n_fail;

    cmp_operand_sequencer_if #(.WIDTH(8)) bus1 ();
    cmp_operand_sequencer_if #(.WIDTH(8)) bus4 ();

    cmp_operand_sequencer #(.WIDTH(8), .SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    cmp_operand_sequencer #(.WIDTH(8), .SETTLE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    function automatic logic [5:0] cmp_model(input logic [7:0] a, input logic [7:0] b, input logic force_all);
        logic [5:0] f;
        f[0] = a > b;
        f[1] = a < b;
        f[2] = a >= b;
        f[3] = a <= b;
        f[4] = a == b;
        f[5] = a != b;
        return force_all ? 6'h3F : f;
    endfunction

    // Comparator model: drives its flags only while enabled
    assign bus1.cmp_flags = bus1.cmp_en ? cmp_model(bus1.op_a, bus1.op_b, tb_force) : 6'h00;
    assign bus4.cmp_flags = bus4.cmp_en ? cmp_model(bus4.op_a, bus4.op_b, tb_force) : 6'h00;

    assign bus1.in_data   = tb_in_data;
    assign bus4.in_data   = tb_in_data;
    assign bus1.in_valid  = tb_in_valid & ~sel;
    assign bus4.in_valid  = tb_in_valid & sel;
    assign bus1.out_ready = tb_out_ready;
    assign bus4.out_ready = tb_out_ready;

    wire [7:0] cur_op_a      = sel ? bus4.op_a      : bus1.op_a;
    wire [7:0] cur_op_b      = sel ? bus4.op_b      : bus1.op_b;
    wire       cur_cmp_en    = sel ? bus4.cmp_en    : bus1.cmp_en;
    wire       cur_in_ready  = sel ? bus4.in_ready  : bus1.in_ready;
    wire [5:0] cur_out_flags = sel ? bus4.out_flags : bus1.out_flags;
    wire       cur_out_err   = sel ? bus4.out_err   : bus1.out_err;
    wire       cur_out_valid = sel ? bus4.out_valid : bus1.out_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int gap, input int hold,
                         input int settle, input logic [5:0] ef, input logic ee);
        int edges;
        int en_cycles;
        tb_out_ready = (hold == 0);
        check_eq("in_ready_idle", cur_in_ready, 1);
        tb_in_data  = a;
        tb_in_valid = 1'b1;
        tick();
        tb_in_valid = 1'b0;
        edges = 0;
        repeat (gap) begin
            tick();
            edges++;
        end
        if (gap > 0) check_eq("op_a_gap_hold", cur_op_a, a);
        tb_in_data  = b;
        tb_in_valid = 1'b1;
        tick();
        edges++;
        tb_in_valid = 1'b0;
        en_cycles = 0;
        while (!cur_out_valid && edges < 60) begin
            if (cur_cmp_en) en_cycles++;
            tick();
            edges++;
        end
        check_eq("out_valid_seen", cur_out_valid, 1);
        check_eq("latency_from_a", edges, settle + 1 + gap);
        check_eq("cmp_en_cycles", en_cycles, settle);
        check_eq("cmp_en_released", cur_cmp_en, 0);
        check_eq("out_flags", cur_out_flags, ef);
        check_eq("out_err", cur_out_err, ee);
        check_eq("in_ready_hold", cur_in_ready, 0);
        check_eq("op_a_kept", cur_op_a, a);
        check_eq("op_b_kept", cur_op_b, b);
        if (hold > 0) begin
            tb_in_data  = 8'hAA;
            tb_in_valid = 1'b1;
            repeat (hold) begin
                tick();
                tb_in_valid = 1'b0;
                check_eq("bp_valid", cur_out_valid, 1);
                check_eq("bp_flags", cur_out_flags, ef);
                check_eq("bp_in_ready", cur_in_ready, 0);
            end
            tb_out_ready = 1'b1;
        end
        tick();
        check_eq("done_valid_low", cur_out_valid, 0);
        check_eq("done_in_ready", cur_in_ready, 1);
        check_eq("done_op_a", cur_op_a, a);
    endtask

    task automatic reset_mid(input logic in_hold);
        int guard;
        tb_out_ready = 1'b0;
        tb_in_data   = 8'h44;
        tb_in_valid  = 1'b1;
        tick();
        tb_in_data = 8'h22;
        tick();
        tb_in_valid = 1'b0;
        if (in_hold) begin
            guard = 0;
            while (!cur_out_valid && guard < 40) begin
                tick();
                guard++;
            end
            check_eq("rst_hold_reached", cur_out_valid, 1);
        end else begin
            tick();
            check_eq("rst_eval_cmp_en", cur_cmp_en, 1);
        end
        rst_n = 1'b0;
        tick();
        check_eq("rst_cmp_en", cur_cmp_en, 0);
        check_eq("rst_out_valid", cur_out_valid, 0);
        check_eq("rst_in_ready", cur_in_ready, 1);
        check_eq("rst_op_a", cur_op_a, 0);
        check_eq("rst_op_b", cur_op_b, 0);
        rst_n        = 1'b1;
        tb_out_ready = 1'b1;
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        sel          = 1'b0;
        rst_n        = 1'b0;
        tb_in_data   = 8'h00;
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        tb_force     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("reset_in_ready", bus1.in_ready, 1);
        check_eq("reset_out_valid", bus1.out_valid, 0);
        check_eq("reset_cmp_en", bus1.cmp_en, 0);
        check_eq("reset_out_flags", bus1.out_flags, 0);
        check_eq("reset_out_err", bus1.out_err, 0);
        check_eq("reset_op_a", bus1.op_a, 0);
        check_eq("reset_op_b", bus1.op_b, 0);
        check_eq("reset4_in_ready", bus4.in_ready, 1);

        do_op(8'h05, 8'h03, 0, 0, 1, 6'h25, 1'b0);
        do_op(8'h7F, 8'h7F, 0, 0, 1, 6'h1C, 1'b0);
        do_op(8'h00, 8'hFF, 0, 0, 1, 6'h2A, 1'b0);
        do_op(8'h80, 8'h7F, 0, 0, 1, 6'h25, 1'b0);
        do_op(8'h12, 8'h34, 0, 5, 1, 6'h2A, 1'b0);
        tb_force = 1'b1;
        do_op(8'h10, 8'h20, 0, 0, 1, 6'h3F, 1'b1);
        tb_force = 1'b0;

        sel = 1'b1;
        do_op(8'h09, 8'h09, 3, 0, 4, 6'h1C, 1'b0);
        do_op(8'hC8, 8'h64, 0, 2, 4, 6'h25, 1'b0);
        reset_mid(1'b0);

        sel = 1'b0;
        reset_mid(1'b1);
        do_op(8'h01, 8'h02, 1, 0, 1, 6'h2A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
